riscv_cache_rsp: RTL and testbench

Response/return stage of the data cache. It consumes the request delayed by the preceding stage plus the hit/cacheline lookup result, and returns read data to the core. On a read miss it runs a line-fill burst from the BIU, assembles the line, and writes it into the cache memory. It raises stall to upstream stages while a fill is in progress.

---
 rtl/riscv_cache_pkg.sv | 19 +
 rtl/riscv_cache_fill_buf.sv | 48 ++++
 rtl/riscv_cache_rsp.sv | 163 ++++++++++++++++
 tb/tb_riscv_cache_rsp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_cache_pkg.sv
// rtl/riscv_cache_pkg.sv - shared types and helpers for the data cache response stage
package riscv_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } rsp_state_t;

    function automatic int no_of_beats(input int block_size, input int xlen);
        return block_size / xlen;
    endfunction

    // Word slot of an address inside its cache line.
    function automatic int word_index(input logic [63:0] adr, input int beats, input int xlen);
        return int'((adr >> $clog2(xlen / 8)) & 64'(beats - 1));
    endfunction

endpackage

// File: rtl/riscv_cache_fill_buf.sv
// rtl/riscv_cache_fill_buf.sv - line-fill assembly buffer with wrapping beat pointer
module riscv_cache_fill_buf #(
    parameter int XLEN  = 32,
    parameter int BEATS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic [$clog2(BEATS)-1:0] i_start,
    input  logic                     i_we,
    input  logic [XLEN-1:0]          i_d,
    output logic [$clog2(BEATS)-1:0] o_cnt,
    output logic                     o_first,
    output logic                     o_done,
    output logic [BEATS*XLEN-1:0]    o_line
);

    localparam int BEAT_BITS = $clog2(BEATS);

    logic [XLEN-1:0]      r_buf [BEATS];
    logic [BEAT_BITS-1:0] r_cnt;
    logic [BEAT_BITS-1:0] r_nbeat;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_nbeat <= '0;
            for (int i = 0; i < BEATS; i++) r_buf[i] <= '0;
        end else if (i_load) begin
            r_cnt   <= i_start;
            r_nbeat <= '0;
        end else if (i_we) begin
            r_buf[r_cnt] <= i_d;
            r_cnt        <= r_cnt + 1'b1;
            r_nbeat      <= r_nbeat + 1'b1;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_first = (r_nbeat == '0);
    assign o_done  = i_we & (r_nbeat == BEAT_BITS'(BEATS - 1));

    always_comb begin
        o_line = '0;
        for (int i = 0; i < BEATS; i++) o_line[i*XLEN +: XLEN] = r_buf[i];
    end

endmodule

// File: rtl/riscv_cache_rsp.sv
// rtl/riscv_cache_rsp.sv - data cache response stage with line fill; CACHE_CWF_EN selects critical-word-first
module riscv_cache_rsp
    import riscv_cache_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PLEN       = XLEN,
    parameter int BLOCK_SIZE = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  req_i,
    input  logic                  wreq_i,
    input  logic [PLEN-1:0]       adr_i,
    input  logic [XLEN/8-1:0]     be_i,
    input  logic                  hit_i,
    input  logic [BLOCK_SIZE-1:0] line_i,
    output logic                  biu_req_o,
    output logic [PLEN-1:0]       biu_adr_o,
    input  logic                  biu_ack_i,
    input  logic [XLEN-1:0]       biu_d_i,
    input  logic                  biu_err_i,
    output logic                  stall_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [XLEN-1:0]       q_o,
    output logic                  fill_we_o,
    output logic [PLEN-1:0]       fill_adr_o,
    output logic [BLOCK_SIZE-1:0] fill_line_o
);

    localparam int BEATS     = no_of_beats(BLOCK_SIZE, XLEN);
    localparam int BEAT_BITS = $clog2(BEATS);
    localparam logic [PLEN-1:0] LINE_MASK = ~PLEN'(BLOCK_SIZE / 8 - 1);
    localparam logic [PLEN-1:0] WORD_MASK = ~PLEN'(XLEN / 8 - 1);

    rsp_state_t           r_state;
    logic [BEAT_BITS-1:0] r_widx;
    logic                 r_kill;
    logic                 r_biu_req;
    logic [PLEN-1:0]      r_biu_adr;
    logic                 r_ack;
    logic                 r_err;
    logic [XLEN-1:0]      r_q;
    logic                 r_fill_we;
    logic [PLEN-1:0]      r_fill_adr;

    logic                 w_idle, w_hit, w_miss, w_kill, w_beat_we, w_berr;
    logic [BEAT_BITS-1:0] w_widx, w_start_beat, w_cnt;
    logic [PLEN-1:0]      w_start_adr;
    logic                 w_first, w_done;
    logic [XLEN-1:0]      w_crit;
    logic                 w_unused;

    assign w_idle    = (r_state == IDLE);
    assign w_hit     = w_idle & req_i & ~wreq_i & hit_i & ~flush_i;
    assign w_miss    = w_idle & req_i & ~wreq_i & ~hit_i & ~flush_i;
    assign w_kill    = r_kill | flush_i;
    assign w_beat_we = (r_state == FILL) & biu_ack_i & ~biu_err_i;
    assign w_berr    = (r_state == FILL) & biu_err_i;
    assign w_widx    = BEAT_BITS'(word_index(64'(adr_i), BEATS, XLEN));

`ifdef CACHE_CWF_EN
    assign w_start_beat = w_widx;
    assign w_start_adr  = adr_i & WORD_MASK;
`else
    assign w_start_beat = '0;
    assign w_start_adr  = adr_i & LINE_MASK;
`endif

    riscv_cache_fill_buf #(.XLEN(XLEN), .BEATS(BEATS)) u_fill_buf (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_load  (w_miss),
        .i_start (w_start_beat),
        .i_we    (w_beat_we),
        .i_d     (biu_d_i),
        .o_cnt   (w_cnt),
        .o_first (w_first),
        .o_done  (w_done),
        .o_line  (fill_line_o)
    );

    // The last beat is still on the bus when the line completes, so bypass it.
    assign w_crit   = (w_cnt == r_widx) ? biu_d_i : fill_line_o[r_widx*XLEN +: XLEN];
    assign w_unused = ^{be_i, w_first, w_crit};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_widx     <= '0;
            r_kill     <= 1'b0;
            r_biu_req  <= 1'b0;
            r_biu_adr  <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_q        <= '0;
            r_fill_we  <= 1'b0;
            r_fill_adr <= '0;
        end else begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_fill_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_kill <= 1'b0;
                    if (w_hit) begin
                        r_ack <= 1'b1;
                        r_q   <= line_i[w_widx*XLEN +: XLEN];
                    end else if (w_miss) begin
                        r_state    <= FILL;
                        r_biu_req  <= 1'b1;
                        r_biu_adr  <= w_start_adr;
                        r_widx     <= w_widx;
                        r_fill_adr <= adr_i & LINE_MASK;
                    end
                end
                FILL: begin
                    if (flush_i) r_kill <= 1'b1;
                    if (w_berr) begin
                        r_state   <= IDLE;
                        r_biu_req <= 1'b0;
                        r_err     <= ~w_kill;
                        r_kill    <= 1'b0;
                    end else if (w_beat_we) begin
`ifdef CACHE_CWF_EN
                        if (w_first && !w_kill) begin
                            r_ack <= 1'b1;
                            r_q   <= biu_d_i;
                        end
`endif
                        if (w_done) begin
                            r_state   <= WRITE;
                            r_biu_req <= 1'b0;
                            r_fill_we <= 1'b1;
`ifndef CACHE_CWF_EN
                            if (!w_kill) begin
                                r_ack <= 1'b1;
                                r_q   <= w_crit;
                            end
`endif
                        end
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                    r_kill  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall_o    = ~w_idle | w_miss;
    assign biu_req_o  = r_biu_req;
    assign biu_adr_o  = w_idle ? w_start_adr : r_biu_adr;
    assign ack_o      = r_ack;
    assign err_o      = r_err;
    assign q_o        = r_q;
    assign fill_we_o  = r_fill_we;
    assign fill_adr_o = r_fill_adr;

endmodule

// File: tb/tb_riscv_cache_rsp.sv
// tb/tb_riscv_cache_rsp.sv - directed self-checking bench for riscv_cache_rsp
module tb_riscv_cache_rsp;

    localparam int XLEN = 32;
    localparam int PLEN = 32;
    localparam int BLOCK_SIZE = 256;
    localparam int BEATS = 8;
`ifdef CACHE_CWF_EN
    localparam int CWF = 1;
    localparam int START_BEAT = 5;
    localparam logic [31:0] START_ADR = 32'h114;
`else
    localparam int CWF = 0;
    localparam int START_BEAT = 0;
    localparam logic [31:0] START_ADR = 32'h100;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni, flush_i, req_i, wreq_i, hit_i, biu_ack_i, biu_err_i;
    logic [PLEN-1:0] adr_i;
    logic [XLEN/8-1:0] be_i;
    logic [BLOCK_SIZE-1:0] line_i;
    logic [XLEN-1:0] biu_d_i;
    logic biu_req_o, stall_o, ack_o, err_o, fill_we_o;
    logic [PLEN-1:0] biu_adr_o, fill_adr_o;
    logic [XLEN-1:0] q_o;
    logic [BLOCK_SIZE-1:0] fill_line_o;

    riscv_cache_rsp #(.XLEN(XLEN), .PLEN(PLEN), .BLOCK_SIZE(BLOCK_SIZE)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i), .wreq_i(wreq_i),
        .adr_i(adr_i), .be_i(be_i), .hit_i(hit_i), .line_i(line_i),
        .biu_req_o(biu_req_o), .biu_adr_o(biu_adr_o), .biu_ack_i(biu_ack_i),
        .biu_d_i(biu_d_i), .biu_err_i(biu_err_i), .stall_o(stall_o), .ack_o(ack_o),
        .err_o(err_o), .q_o(q_o), .fill_we_o(fill_we_o), .fill_adr_o(fill_adr_o),
        .fill_line_o(fill_line_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic        wreq;
        logic        hit;
        logic        flush;
        logic [31:0] adr;
        logic        exp_stall;
        logic        exp_ack;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs[8];

    int n_ack, n_err, n_we, ack_cyc, we_cyc, beats;
    logic [31:0] ack_q;
    logic [255:0] we_line, exp_line;

    // One read miss at 0x114 with the BIU acking every cycle; data = beat word index.
    task automatic run_fill(input string tag, input int err_beat, input int flush_beat, input int rst_beat);
        n_ack = 0; n_err = 0; n_we = 0; ack_cyc = -1; we_cyc = -2; beats = 0;
        ack_q = '0; we_line = '0;
        req_i = 1'b1; wreq_i = 1'b0; hit_i = 1'b0; adr_i = 32'h114;
        #1;
        chk({tag, "_stall_same_cycle"}, 256'(stall_o), 256'(1));
        chk({tag, "_biu_adr"}, 256'(biu_adr_o), 256'(START_ADR));
        tick();
        req_i = 1'b0;
        chk({tag, "_biu_req"}, 256'(biu_req_o), 256'(1));
        chk({tag, "_fill_adr"}, 256'(fill_adr_o), 256'(32'h100));
        for (int c = 0; c < 30; c++) begin
            if (biu_req_o && beats < BEATS) begin
                biu_ack_i = 1'b1;
                biu_d_i   = (START_BEAT + beats) % BEATS;
                biu_err_i = (beats == err_beat);
                flush_i   = (beats == flush_beat);
                if (beats == rst_beat) rst_ni = 1'b0;
                beats++;
            end
            tick();
            biu_ack_i = 1'b0; biu_err_i = 1'b0; flush_i = 1'b0;
            if (!rst_ni) begin
                chk({tag, "_rst_biu_req"}, 256'(biu_req_o), 256'(0));
                chk({tag, "_rst_stall"}, 256'(stall_o), 256'(0));
                chk({tag, "_rst_ack_err_we"}, 256'({ack_o, err_o, fill_we_o}), 256'(0));
                chk({tag, "_rst_q"}, 256'(q_o), 256'(0));
                chk({tag, "_rst_fill_adr"}, 256'(fill_adr_o), 256'(0));
                chk({tag, "_rst_fill_line"}, fill_line_o, 256'(0));
                rst_ni = 1'b1;
                return;
            end
            if (ack_o) begin n_ack++; ack_q = q_o; ack_cyc = c; end
            if (err_o) n_err++;
            if (fill_we_o) begin n_we++; we_cyc = c; we_line = fill_line_o; end
            if (!stall_o) break;
        end
        chk({tag, "_terminates"}, 256'(stall_o), 256'(0));
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; req_i = 1'b0; wreq_i = 1'b0; hit_i = 1'b0;
        adr_i = '0; be_i = '1; biu_ack_i = 1'b0; biu_err_i = 1'b0; biu_d_i = '0;
        for (int k = 0; k < BEATS; k++) line_i[k*32 +: 32] = 32'hA000_0000 + k;
        line_i[32 +: 32] = 32'hDEAD_BEEF;
        for (int k = 0; k < BEATS; k++) exp_line[k*32 +: 32] = k;

        //            req   wreq  hit   flush adr          stall ack   q
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h11C, 1'b0, 1'b1, 32'hA000_0007};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'hA000_0000};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h114, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10E, 1'b0, 1'b1, 32'hA000_0003};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10C, 1'b0, 1'b0, 32'h0};

        tick(); tick();
        chk("reset_biu_req", 256'(biu_req_o), 256'(0));
        chk("reset_stall", 256'(stall_o), 256'(0));
        chk("reset_ack_err_we", 256'({ack_o, err_o, fill_we_o}), 256'(0));
        chk("reset_q", 256'(q_o), 256'(0));
        chk("reset_fill_adr", 256'(fill_adr_o), 256'(0));
        chk("reset_fill_line", fill_line_o, 256'(0));
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            req_i = vecs[i].req; wreq_i = vecs[i].wreq; hit_i = vecs[i].hit;
            flush_i = vecs[i].flush; adr_i = vecs[i].adr;
            #1;
            chk($sformatf("vec%0d_stall", i), 256'(stall_o), 256'(vecs[i].exp_stall));
            tick();
            chk($sformatf("vec%0d_ack", i), 256'(ack_o), 256'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_biu_req", i), 256'(biu_req_o), 256'(0));
            if (vecs[i].exp_ack) chk($sformatf("vec%0d_q", i), 256'(q_o), 256'(vecs[i].exp_q));
        end
        req_i = 1'b0; wreq_i = 1'b0; hit_i = 1'b0; flush_i = 1'b0;
        tick();

        run_fill("miss", -1, -1, -1);
        chk("miss_beats", 256'(beats), 256'(8));
        chk("miss_fill_we_count", 256'(n_we), 256'(1));
        chk("miss_ack_count", 256'(n_ack), 256'(1));
        chk("miss_err_count", 256'(n_err), 256'(0));
        chk("miss_q", 256'(ack_q), 256'(5));
        chk("miss_line", we_line, exp_line);
        if (CWF != 0) chk("miss_ack_after_first_beat", 256'(ack_cyc), 256'(0));
        else          chk("miss_ack_with_fill_we", 256'(ack_cyc), 256'(we_cyc));
        tick();

        run_fill("err", 3, -1, -1);
        chk("err_count", 256'(n_err), 256'(1));
        chk("err_ack_count", 256'(n_ack), 256'(CWF));
        chk("err_fill_we_count", 256'(n_we), 256'(0));
        chk("err_biu_req", 256'(biu_req_o), 256'(0));
        chk("err_beats", 256'(beats), 256'(4));
        tick();

        run_fill("flush", -1, 2, -1);
        chk("flush_beats", 256'(beats), 256'(8));
        chk("flush_fill_we_count", 256'(n_we), 256'(1));
        chk("flush_ack_count", 256'(n_ack), 256'(CWF));
        chk("flush_err_count", 256'(n_err), 256'(0));
        tick();

        run_fill("rst", -1, -1, 4);
        req_i = 1'b1; wreq_i = 1'b0; hit_i = 1'b1; adr_i = 32'h104;
        tick();
        req_i = 1'b0; hit_i = 1'b0;
        chk("post_rst_hit_ack", 256'(ack_o), 256'(1));
        chk("post_rst_hit_q", 256'(q_o), 256'(32'hDEAD_BEEF));
        tick();
        chk("post_rst_ack_single", 256'(ack_o), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
